// File: rtl/mips_cpu_perf_cnt.sv
// mips_cpu_perf_cnt: bank of event counters with sticky overflow flags and a
// snapshot streamer. The streamer copies all counters into a shadow register
// and then shifts the copy out one byte per cycle: counter 0 first, least
// significant byte first.
module mips_cpu_perf_cnt #(
   parameter int NUM_CNT   = 8,   // number of event counters, 1..16
   parameter int CNT_WIDTH = 32,  // bits per counter, 8..32, multiple of 8
   parameter int SAT_MODE  = 0    // 0 = wrap at all-ones, 1 = saturate
) (
   input  logic                 mips_cpu_clk,
   input  logic                 mips_cpu_reset,
   input  logic                 cnt_en,
   input  logic [NUM_CNT-1:0]   cnt_event,
   input  logic                 cnt_clear,
   input  logic                 snap_req,
   output logic                 snap_busy,
   output logic [7:0]           mips_cpu_perf_sig,
   output logic                 perf_valid,
   output logic                 perf_last,
   output logic [NUM_CNT-1:0]   ovf_flag
);

   localparam int BYTES_PER_CNT = CNT_WIDTH / 8;
   localparam int NUM_BYTES     = NUM_CNT * BYTES_PER_CNT;
   localparam int IDX_W         = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_BYTES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   logic [CNT_WIDTH-1:0]         cnt_q [NUM_CNT];
   logic [NUM_CNT*CNT_WIDTH-1:0] cnt_flat;
   logic [NUM_BYTES-1:0][7:0]    shadow_q;
   logic [IDX_W-1:0]             byte_idx_q;
   state_t                       state_q;
   state_t                       state_d;
   logic                         snap_take;

   // Event counters and sticky overflow flags; clear beats any same-cycle event.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values, which is what lets the shadow capture the pre-update count.
   always_ff @(posedge mips_cpu_clk or posedge mips_cpu_reset) begin
      if (mips_cpu_reset) begin
         for (int i = 0; i < NUM_CNT; i++) begin
            cnt_q[i] <= '0;
         end
         ovf_flag <= '0;
      end else if (cnt_clear) begin
         for (int i = 0; i < NUM_CNT; i++) begin
            cnt_q[i] <= '0;
         end
         ovf_flag <= '0;
      end else begin
         for (int i = 0; i < NUM_CNT; i++) begin
            if (cnt_en && cnt_event[i]) begin
               if (cnt_q[i] == CNT_MAX) begin
                  ovf_flag[i] <= 1'b1;
                  cnt_q[i]    <= (SAT_MODE != 0) ? CNT_MAX : '0;
               end else begin
                  cnt_q[i] <= cnt_q[i] + 1'b1;
               end
            end
         end
      end
   end

   // Pack the counter array into one vector, counter 0 in the low bits.
   always_comb begin
      cnt_flat = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
         cnt_flat[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
      end
   end

   // Stream FSM state register.
   always_ff @(posedge mips_cpu_clk or posedge mips_cpu_reset) begin
      if (mips_cpu_reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and stream outputs; outputs are forced to zero outside STREAM.
   // NOTE: every signal written here gets a default first, so no path leaves a
   // value unassigned and no latch is inferred.
   always_comb begin
      state_d           = state_q;
      snap_take         = 1'b0;
      perf_valid        = 1'b0;
      snap_busy         = 1'b0;
      perf_last         = 1'b0;
      mips_cpu_perf_sig = 8'h00;
      case (state_q)
         IDLE: begin
            if (snap_req) begin
               snap_take = 1'b1;
               state_d   = STREAM;
            end
         end
         STREAM: begin
            perf_valid        = 1'b1;
            snap_busy         = 1'b1;
            mips_cpu_perf_sig = shadow_q[byte_idx_q];
            if (byte_idx_q == LAST_IDX) begin
               perf_last = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Shadow capture on an accepted request, then byte index advance while streaming.
   // NOTE: the shadow is a wide register rather than a RAM, so it takes the
   // asynchronous reset and an aborted stream can never leak stale data.
   always_ff @(posedge mips_cpu_clk or posedge mips_cpu_reset) begin
      if (mips_cpu_reset) begin
         shadow_q   <= '0;
         byte_idx_q <= '0;
      end else if (snap_take) begin
         shadow_q   <= cnt_flat;
         byte_idx_q <= '0;
      end else if (state_q == STREAM) begin
         byte_idx_q <= perf_last ? '0 : byte_idx_q + IDX_W'(1);
      end
   end

endmodule

// File: tb/tb_mips_cpu_perf_cnt.sv
// Testbench for mips_cpu_perf_cnt: table-driven per-cycle vectors on the
// default configuration plus directed sequences for overflow, streaming under
// load and asynchronous reset. Two extra 8-bit instances cover wrap/saturate.
module tb_mips_cpu_perf_cnt;

   logic       clk = 1'b0;
   logic       rst;
   logic       cnt_en;
   logic [7:0] cnt_event;
   logic       cnt_clear;
   logic       snap_req;

   logic       busy, valid, last;
   logic [7:0] sig, ovf;
   logic       busy_w, valid_w, last_w;
   logic [7:0] sig_w;
   logic [1:0] ovf_w;
   logic       busy_s, valid_s, last_s;
   logic [7:0] sig_s;
   logic [1:0] ovf_s;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic       en;
      logic [7:0] ev;
      logic       clr;
      logic       snap;
      logic       valid;
      logic       last;
      logic [7:0] sig;
      logic [7:0] ovf;
   } vec_t;

   vec_t       tbl[$];
   logic [7:0] exp_b[32];

   always #5 clk = ~clk;

   mips_cpu_perf_cnt dut (
      .mips_cpu_clk(clk), .mips_cpu_reset(rst), .cnt_en(cnt_en),
      .cnt_event(cnt_event), .cnt_clear(cnt_clear), .snap_req(snap_req),
      .snap_busy(busy), .mips_cpu_perf_sig(sig), .perf_valid(valid),
      .perf_last(last), .ovf_flag(ovf)
   );

   mips_cpu_perf_cnt #(.NUM_CNT(2), .CNT_WIDTH(8), .SAT_MODE(0)) dut_w (
      .mips_cpu_clk(clk), .mips_cpu_reset(rst), .cnt_en(cnt_en),
      .cnt_event(cnt_event[1:0]), .cnt_clear(cnt_clear), .snap_req(snap_req),
      .snap_busy(busy_w), .mips_cpu_perf_sig(sig_w), .perf_valid(valid_w),
      .perf_last(last_w), .ovf_flag(ovf_w)
   );

   mips_cpu_perf_cnt #(.NUM_CNT(2), .CNT_WIDTH(8), .SAT_MODE(1)) dut_s (
      .mips_cpu_clk(clk), .mips_cpu_reset(rst), .cnt_en(cnt_en),
      .cnt_event(cnt_event[1:0]), .cnt_clear(cnt_clear), .snap_req(snap_req),
      .snap_busy(busy_s), .mips_cpu_perf_sig(sig_s), .perf_valid(valid_s),
      .perf_last(last_s), .ovf_flag(ovf_s)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: rising edge, then land on the falling edge for checks/drive.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic en, input logic [7:0] ev, input logic clr, input logic snap);
      cnt_en    = en;
      cnt_event = ev;
      cnt_clear = clr;
      snap_req  = snap;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " valid"}, valid, 0);
      check({tag, " busy"},  busy, 0);
      check({tag, " sig"},   sig, 0);
      check({tag, " last"},  last, 0);
      check({tag, " ovf"},   ovf, 0);
      check({tag, " w out"}, {valid_w, busy_w, last_w, sig_w, ovf_w}, 0);
      check({tag, " s out"}, {valid_s, busy_s, last_s, sig_s, ovf_s}, 0);
   endtask

   // Reset asserted away from any edge, checked before the clock, held over one edge.
   task automatic do_reset(input string tag);
      drive(0, 8'h00, 0, 0);
      #2 rst = 1'b1;
      #1 check_all_zero(tag);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Check a 32-byte stream against exp_b; inputs stay as the caller left them.
   task automatic stream_check(input string tag);
      for (int k = 0; k < 32; k++) begin
         check($sformatf("%s byte%0d sig", tag, k), sig, exp_b[k]);
         check($sformatf("%s byte%0d flags", tag, k), {valid, busy, last},
               {2'b11, (k == 31)});
         step();
      end
      check({tag, " busy after last"}, {busy, valid, sig}, 0);
   endtask

   function automatic void add(input logic en, input logic [7:0] ev, input logic clr,
                               input logic snap, input logic v, input logic l,
                               input logic [7:0] s, input logic [7:0] o);
      vec_t r;
      r.en = en; r.ev = ev; r.clr = clr; r.snap = snap;
      r.valid = v; r.last = l; r.sig = s; r.ovf = o;
      tbl.push_back(r);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0;
      drive(0, 8'h00, 0, 0);

      // Table: counters 0 and 2 count three events, then a full stream;
      // then counter 1 to 5 and a clear colliding with an event, then a stream.
      for (int i = 0; i < 3; i++) add(1, 8'h05, 0, 0, 0, 0, 8'h00, 8'h00);
      add(0, 8'h00, 0, 1, 1, 0, 8'h03, 8'h00);
      for (int k = 1; k < 32; k++)
         add(0, 8'h00, 0, 0, 1, (k == 31), (k == 8) ? 8'h03 : 8'h00, 8'h00);
      add(0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
      for (int i = 0; i < 5; i++) add(1, 8'h02, 0, 0, 0, 0, 8'h00, 8'h00);
      add(1, 8'h02, 1, 0, 0, 0, 8'h00, 8'h00);
      add(0, 8'h00, 0, 1, 1, 0, 8'h00, 8'h00);
      for (int k = 1; k < 32; k++) add(0, 8'h00, 0, 0, 1, (k == 31), 8'h00, 8'h00);
      add(0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);

      do_reset("reset0");
      foreach (tbl[i]) begin
         drive(tbl[i].en, tbl[i].ev, tbl[i].clr, tbl[i].snap);
         step();
         check($sformatf("row%0d sig", i), sig, tbl[i].sig);
         check($sformatf("row%0d valid/busy/last", i), {valid, busy, last},
               {tbl[i].valid, tbl[i].valid, tbl[i].last});
         check($sformatf("row%0d ovf", i), ovf, tbl[i].ovf);
      end

      // 8-bit wrap and saturate: 257 events on counter 0.
      do_reset("reset1");
      drive(1, 8'h01, 0, 0);
      repeat (255) step();
      check("ovf before wrap w", ovf_w, 2'b00);
      check("ovf before wrap s", ovf_s, 2'b00);
      step();
      check("ovf at wrap w", ovf_w, 2'b01);
      check("ovf at wrap s", ovf_s, 2'b01);
      step();
      drive(0, 8'h00, 0, 1);
      step();
      drive(0, 8'h00, 0, 0);
      check("wrap cnt0", sig_w, 8'h01);
      check("sat cnt0", sig_s, 8'hFF);
      check("wide cnt0 b0", sig, 8'h01);
      check("small byte0 last", {last_w, last_s}, 2'b00);
      step();
      check("wrap cnt1", {sig_w, last_w, valid_w}, {8'h00, 2'b11});
      check("sat cnt1", {sig_s, last_s, valid_s}, {8'h00, 2'b11});
      check("wide cnt0 b1", sig, 8'h01);
      check("ovf held w", ovf_w, 2'b01);
      step();
      check("small idle", {valid_w, busy_w, valid_s, busy_s}, 4'b0000);
      for (int n = 0; n < 100 && busy; n++) step();
      check("wide stream ended", busy, 0);
      drive(0, 8'h00, 1, 0);
      step();
      drive(0, 8'h00, 0, 0);
      check("clear ovf w", ovf_w, 2'b00);
      check("clear ovf s", ovf_s, 2'b00);

      // Stream under load: events and repeated requests must not disturb it.
      do_reset("reset2");
      drive(1, 8'h05, 0, 0);
      repeat (3) step();
      drive(0, 8'h00, 0, 1);
      step();
      drive(1, 8'hFF, 0, 1);
      for (int k = 0; k < 32; k++) exp_b[k] = (k == 0 || k == 8) ? 8'h03 : 8'h00;
      stream_check("load");
      drive(0, 8'h00, 0, 0);
      step();
      check("no queued request", {busy, valid}, 2'b00);
      drive(0, 8'h00, 0, 1);
      step();
      drive(0, 8'h00, 0, 0);
      for (int k = 0; k < 32; k++)
         exp_b[k] = (k % 4 != 0) ? 8'h00 : ((k == 0 || k == 8) ? 8'h23 : 8'h20);
      stream_check("after load");

      // Reset mid-stream at byte 10 aborts and the next stream is all zeros.
      do_reset("reset3");
      drive(1, 8'h05, 0, 0);
      repeat (3) step();
      drive(0, 8'h00, 0, 1);
      step();
      drive(0, 8'h00, 0, 0);
      repeat (10) step();
      check("byte10 live", {valid, busy}, 2'b11);
      #2 rst = 1'b1;
      #1 check("abort out", {valid, busy, last, sig}, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      step();
      check("no resume", {valid, busy}, 2'b00);
      drive(0, 8'h00, 0, 1);
      step();
      drive(0, 8'h00, 0, 0);
      for (int k = 0; k < 32; k++) exp_b[k] = 8'h00;
      stream_check("post reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
